// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg: pixel/window types and FSM encoding shared by window_generator and the conv stage.
// Rev 1.0
package conv_pkg;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0]       pixel_t;
  typedef logic [8:0][PIX_W-1:0]  window_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } win_state_e;
endpackage
`default_nettype wire

// File: rtl/window_generator_if.sv
`default_nettype none
// window_generator_if: pixel stream in, 3x3 window out; win_row/win_col exist only with WINDOW_POS_EN.
// Rev 1.0
interface window_generator_if
`ifdef WINDOW_POS_EN
  #(parameter int IMG_WIDTH = 64, parameter int IMG_HEIGHT = 64)
`endif
  ();
  import conv_pkg::*;

  logic    in_sof;
  logic    in_valid;
  pixel_t  in_pixel;
  logic    win_valid;
  window_t window;
  logic    frame_done;

`ifdef WINDOW_POS_EN
  logic [$clog2(IMG_HEIGHT)-1:0] win_row;
  logic [$clog2(IMG_WIDTH)-1:0]  win_col;

  modport master (output in_sof, in_valid, in_pixel,
                  input  win_valid, window, frame_done, win_row, win_col);
  modport slave  (input  in_sof, in_valid, in_pixel,
                  output win_valid, window, frame_done, win_row, win_col);
`else
  modport master (output in_sof, in_valid, in_pixel,
                  input  win_valid, window, frame_done);
  modport slave  (input  in_sof, in_valid, in_pixel,
                  output win_valid, window, frame_done);
`endif
endinterface
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// line_buffer: DEPTH-entry pixel row store, synchronous write, combinational read, shared address.
// Rev 1.0
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  pixel_t                   i_wdata,
  output pixel_t                   o_rdata
);
  pixel_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule
`default_nettype wire

// File: rtl/window_generator.sv
`default_nettype none
// window_generator: raster pixels -> 3x3 neighbourhoods via two line buffers (no border padding).
// Rev 1.0 -- define WINDOW_POS_EN to add win_row/win_col centre coordinates.
module window_generator
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic              clk,
  input  logic              rst,
  window_generator_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_e    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  window_t       r_window;
  logic          r_win_valid;
  logic          r_frame_done;

  pixel_t        w_lb1_rd;
  pixel_t        w_lb2_rd;
  logic          w_start;
  logic          w_active;
  logic          w_accept;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_row_end;
  logic          w_frame_end;
  logic          w_emit;

  // A qualified sof always restarts at (0,0), whatever the current position.
  assign w_start     = bus.in_valid & bus.in_sof;
  assign w_active    = (r_state == FILL) || (r_state == STREAM);
  assign w_accept    = w_start | (bus.in_valid & w_active);
  assign w_col       = w_start ? '0 : r_col;
  assign w_row       = w_start ? '0 : r_row;
  assign w_row_end   = (w_col == COL_LAST);
  assign w_frame_end = w_row_end && (w_row == ROW_LAST);
  assign w_emit      = w_accept && (w_row >= ROW_TWO) && (w_col >= COL_TWO);

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (bus.in_pixel),
    .o_rdata (w_lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb2_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_window     <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_accept) begin
        // Shift columns left; new right column is {row-2, row-1, current} top to bottom.
        r_window    <= {r_window[7:6], w_lb2_rd,
                        r_window[4:3], w_lb1_rd,
                        r_window[1:0], bus.in_pixel};
        r_win_valid <= w_emit;
        r_col       <= w_row_end ? '0 : w_col + 1'b1;
        if (w_row_end) r_row <= w_frame_end ? '0 : w_row + 1'b1;
        else           r_row <= w_row;
      end

      if (w_start) begin
        r_state <= FILL;
      end else begin
        unique case (r_state)
          FILL: begin
            if (w_accept && w_row_end && (w_row == ROW_ONE)) r_state <= STREAM;
          end
          STREAM: begin
            if (w_accept && w_frame_end) begin
              r_state      <= DONE;
              r_frame_done <= 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.win_valid  = r_win_valid;
  assign bus.window     = r_window;
  assign bus.frame_done = r_frame_done;

`ifdef WINDOW_POS_EN
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_row <= '0;
      r_win_col <= '0;
    end else if (w_emit) begin
      r_win_row <= w_row - 1'b1;
      r_win_col <= w_col - 1'b1;
    end
  end

  assign bus.win_row = r_win_row;
  assign bus.win_col = r_win_col;
`endif
endmodule
`default_nettype wire

// File: tb/tb_window_generator.sv
`default_nettype none
// tb_window_generator: directed vector tables on a 5x4 instance plus a 3x3 instance.
module tb_window_generator;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef WINDOW_POS_EN
  window_generator_if #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) bus_a ();
  window_generator_if #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) bus_b ();
`else
  window_generator_if bus_a ();
  window_generator_if bus_b ();
`endif

  window_generator #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  window_generator #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic    sof;
    logic    valid;
    pixel_t  pix;
    logic    exp_wv;
    logic    exp_fd;
    logic    chk_win;
    window_t exp_win;
    int      exp_row;
    int      exp_col;
  } vec_t;

  vec_t    vecs [$];
  window_t got_q [$];
  int      fd_cnt;
  int      n_pass  = 0;
  int      n_total = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Valid pixels without sof while idle; window must stay at its reset value.
  task automatic add_drops(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.sof = 1'b0; v.valid = 1'b1; v.pix = pixel_t'(8'h55 + i);
      v.exp_wv = 1'b0; v.exp_fd = 1'b0; v.chk_win = 1'b1; v.exp_win = '0;
      v.exp_row = 0; v.exp_col = 0;
      vecs.push_back(v);
    end
  endtask

  // First npix pixels of a 5x4 frame with pixel = 10*row + col, then one idle cycle.
  // With gaps, every accept is followed by an idle cycle carrying a stray (unqualified) sof.
  task automatic add_frame(input int npix, input bit gaps);
    vec_t    v;
    window_t w;
    int      r;
    int      c;
    for (int i = 0; i < npix; i++) begin
      r = i / 5;
      c = i % 5;
      v.sof = (i == 0); v.valid = 1'b1; v.pix = pixel_t'(10 * r + c);
      v.exp_wv = (r >= 2) && (c >= 2);
      v.exp_fd = (r == 3) && (c == 4);
      for (int k = 0; k < 9; k++) begin
        w[k] = pixel_t'(10 * (r - 2 + (8 - k) / 3) + (c - 2 + (8 - k) % 3));
      end
      v.exp_win = w; v.chk_win = v.exp_wv;
      v.exp_row = r - 1; v.exp_col = c - 1;
      vecs.push_back(v);
      if (gaps || (i == npix - 1)) begin
        v.sof = gaps; v.valid = 1'b0; v.pix = 8'hEE;
        v.exp_wv = 1'b0; v.exp_fd = 1'b0;
        vecs.push_back(v);
      end
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      bus_a.in_sof   = vecs[i].sof;
      bus_a.in_valid = vecs[i].valid;
      bus_a.in_pixel = vecs[i].pix;
      @(posedge clk); #1;
      check($sformatf("v%0d win_valid", i), 72'(bus_a.win_valid), 72'(vecs[i].exp_wv));
      check($sformatf("v%0d frame_done", i), 72'(bus_a.frame_done), 72'(vecs[i].exp_fd));
      if (vecs[i].chk_win) check($sformatf("v%0d window", i), bus_a.window, vecs[i].exp_win);
`ifdef WINDOW_POS_EN
      if (vecs[i].exp_wv) begin
        check($sformatf("v%0d win_row", i), 72'(bus_a.win_row), 72'(vecs[i].exp_row));
        check($sformatf("v%0d win_col", i), 72'(bus_a.win_col), 72'(vecs[i].exp_col));
      end
`endif
      if (bus_a.win_valid) got_q.push_back(bus_a.window);
      if (bus_a.frame_done) fd_cnt++;
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_sof   = 1'b0;
  endtask

  task automatic start_scenario();
    vecs.delete();
    got_q.delete();
    fd_cnt = 0;
  endtask

  window_t exp_b;
  int      fd_b;

  initial begin
    rst = 1'b0;
    bus_a.in_sof = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_pixel = '0;
    bus_b.in_sof = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset win_valid", 72'(bus_a.win_valid), 72'(0));
    check("reset window", bus_a.window, 72'(0));
    check("reset frame_done", 72'(bus_a.frame_done), 72'(0));
    rst = 1'b1;

    // Continuous 5x4 frame, preceded by dropped non-sof pixels.
    start_scenario();
    add_drops(3);
    add_frame(20, 1'b0);
    run_vecs();
    check("cont window count", 72'(got_q.size()), 72'(6));
    check("cont frame_done count", 72'(fd_cnt), 72'(1));
    if (got_q.size() == 6) begin
      check("first [8]", 72'(got_q[0][8]), 72'(0));
      check("first [4]", 72'(got_q[0][4]), 72'(11));
      check("first [0]", 72'(got_q[0][0]), 72'(22));
      check("last [8]", 72'(got_q[5][8]), 72'(12));
      check("last [0]", 72'(got_q[5][0]), 72'(34));
    end

    // Same frame with valid toggling every cycle.
    start_scenario();
    add_frame(20, 1'b1);
    run_vecs();
    check("gap window count", 72'(got_q.size()), 72'(6));
    check("gap frame_done count", 72'(fd_cnt), 72'(1));

    // sof at (2,3) aborts the partial frame, then a full frame.
    start_scenario();
    add_frame(13, 1'b0);
    add_frame(20, 1'b0);
    run_vecs();
    check("abort window count", 72'(got_q.size()), 72'(7));
    check("abort frame_done count", 72'(fd_cnt), 72'(1));

    // Reset during STREAM.
    start_scenario();
    add_frame(14, 1'b0);
    run_vecs();
    bus_a.in_valid = 1'b1; bus_a.in_sof = 1'b0; bus_a.in_pixel = 8'd24;
    @(posedge clk); #1;
    check("pre-reset win_valid", 72'(bus_a.win_valid), 72'(1));
    check("pre-reset window[0]", 72'(bus_a.window[0]), 72'(24));
    bus_a.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async reset win_valid", 72'(bus_a.win_valid), 72'(0));
    check("async reset window", bus_a.window, 72'(0));
    check("async reset frame_done", 72'(bus_a.frame_done), 72'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    start_scenario();
    add_drops(4);
    add_frame(20, 1'b0);
    run_vecs();
    check("post-reset window count", 72'(got_q.size()), 72'(6));
    check("post-reset frame_done count", 72'(fd_cnt), 72'(1));

    // 3x3 frame of pixels 1..9 on the second instance.
    fd_b = 0;
    for (int k = 0; k < 9; k++) exp_b[k] = pixel_t'(9 - k);
    for (int i = 1; i <= 9; i++) begin
      bus_b.in_sof = (i == 1); bus_b.in_valid = 1'b1; bus_b.in_pixel = pixel_t'(i);
      @(posedge clk); #1;
      if (bus_b.frame_done) fd_b++;
      if (i < 9) begin
        check($sformatf("3x3 p%0d win_valid", i), 72'(bus_b.win_valid), 72'(0));
      end else begin
        check("3x3 win_valid", 72'(bus_b.win_valid), 72'(1));
        check("3x3 window", bus_b.window, exp_b);
        check("3x3 frame_done", 72'(bus_b.frame_done), 72'(1));
      end
    end
    bus_b.in_valid = 1'b0; bus_b.in_sof = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus_b.frame_done) fd_b++;
    end
    check("3x3 frame_done count", 72'(fd_b), 72'(1));
    check("3x3 window hold", bus_b.window, exp_b);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/window_generator.md
# window_generator

Upstream neighbour of the 3x3 convolution stage. It accepts a raster-order 8-bit pixel stream and buffers the two previous image rows in line buffers. For every pixel that completes a full 3x3 neighbourhood, it presents the packed 9-pixel window, with a one-cycle valid strobe, to the convolution stage's `window` input. No border padding is applied: a W x H frame yields (W-2)*(H-2) windows.

## Interface
- `IMG_WIDTH`, default 64: pixels per row, minimum 3.
- `IMG_HEIGHT`, default 64: rows per frame, minimum 3.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks pixel (0,0).
- `in_valid`  in  1  `in_pixel` is accepted this cycle. The block always accepts; there is no ready signal.
- `in_pixel`  in  8  unsigned pixel.
- `win_valid`  out  1  `window` holds a new complete neighbourhood this cycle.
- `window`  out  9x8  packed [8:0][7:0]. [8] is top-left, [6] is top-right, [2] is bottom-left, [0] is bottom-right (row-major, descending index).
- `frame_done`  out  1  one-cycle pulse after the last window of a frame.
- `win_row`, `win_col`  out  $clog2(IMG_HEIGHT), $clog2(IMG_WIDTH)  centre coordinates. Present only with `WINDOW_POS_EN`.

## Operation
- Reset values: `win_valid`=0, `window`=0, `frame_done`=0, counters=0, state=IDLE. Line-buffer contents need no reset.
- Counters: `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1. Both advance only on accepted pixels; `col` wraps to 0 and increments `row`.
- Line buffers: `lb1` holds the previous row and `lb2` the row before it, each IMG_WIDTH deep and addressed by `col`. On each accept:
  - read `lb1[col]` and `lb2[col]`;
  - write `lb2[col]` <= old `lb1[col]`;
  - write `lb1[col]` <= `in_pixel`.
- Window register: 3x3 shift array. Each accept shifts the columns left and loads the new right column {`lb2[col]`, `lb1[col]`, `in_pixel`} as top, middle, bottom.
- Valid rule: an accept at (row, col) with row>=2 and col>=2 produces the window centred at (row-1, col-1).
- State machine:
  - IDLE: wait for `in_valid`&`in_sof`, then go to FILL. Pixels without sof are dropped.
  - FILL: rows 0-1 are written to the line buffers; no windows are produced. At the end of row 1, go to STREAM.
  - STREAM: windows are produced per the valid rule. After the accept at (IMG_HEIGHT-1, IMG_WIDTH-1), go to DONE.
  - DONE: pulse `frame_done` for one cycle and go to IDLE.
- Boundaries:
  - sof in any state, including mid-frame, restarts at (0,0) in FILL. The partial frame produces no `frame_done`.
  - Idle cycles (`in_valid`=0) freeze all state. `win_valid` is 0 on those cycles and `window` holds its value.
  - Row wrap: the shift array contains stale columns from the previous row. This is harmless because the first two columns of each row never assert `win_valid`.
  - Reset mid-frame returns the block to IDLE, and the next frame requires sof.

## Timing
- Latency: the accept at cycle t gives `win_valid`/`window` registered at t+1.
- `frame_done` asserts at t+1 after the final accept, in the same cycle as the last `win_valid`.
- Sustained throughput: one pixel per cycle.
- The convolution stage adds its own 3-cycle pipeline. Aligning `win_valid` with `outputPixel` is done by a delay line at the top level, outside this block.

## Configuration
- `WINDOW_POS_EN` defined: add `win_row`/`win_col` outputs, registered together with `window` and giving the centre pixel coordinates (row-1, col-1). Reset value is 0.
- `WINDOW_POS_EN` undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `conv_pkg`:
  - `PIX_W`=8;
  - typedef `pixel_t` (logic[7:0]);
  - typedef `window_t` (logic[8:0][7:0]), which the convolution stage also uses;
  - state enum `win_state_e` {IDLE, FILL, STREAM, DONE}.
- Sub-module `line_buffer`: parameter DEPTH; a synchronous-write, combinational-read array with one write port and one read port. `window_generator` instantiates it twice.

## Test plan
- W=5, H=4, pixel=10*row+col, continuous valid. Expect 6 windows. First window: [8]=0, [4]=11, [0]=22. Last window: [8]=12, [0]=34. `frame_done` is asserted in the same cycle as the 6th `win_valid`.
- Same frame with `in_valid` toggling 1-0 every cycle. Window values are identical to the continuous case and each `win_valid` occurs one cycle after its accept.
- sof at (2,3) mid-frame, then a full frame. No `frame_done` for the aborted frame; the new frame's windows are correct.
- `rst` asserted low during STREAM. All outputs are 0 immediately; pixels without sof are ignored; a subsequent sof frame is correct.
- W=3, H=3, pixels 1..9. Exactly one window {9..1} from [0] to [8], i.e. [8]=1 and [0]=9; `frame_done` pulses once.
- `WINDOW_POS_EN` defined, W=5, H=4. `win_row`/`win_col` sequence is (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
